pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Next-PC controller for the fetch unit of the 5-stage MIPS pipeline.
- Each cycle it chooses NPC from these sources: sequential, branch/jump target, exception handler entry, or ERET return.
- Drives the fetch unit's PC-stall input.
- Keeps a redirect that arrives during a stall, so it is not lost.
- Generates the F/D flush and the branch-delay (BD) flag used by CP0.

Parameters:
- RESET_PC, 32'h00003000, PC value presented on npc while reset is high.
- HANDLER_PC, 32'h00004180, exception/interrupt entry address.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; all state cleared on the clk edge where it is high
- pc  input  32  current fetch PC from the fetch unit
- stall_req  input  1  hazard-unit stall request for F/D
- cti_d  input  1  instruction in D is a branch/jump (delay slot follows)
- redir_d  input  1  D-stage branch taken or jump resolved
- redir_target_d  input  32  target for redir_d
- exc_req  input  1  exception/interrupt committed in M
- eret_req  input  1  ERET committed in M
- epc  input  32  return address from CP0
- npc  output  32  next PC to the fetch unit
- pc_stall  output  1  hold PC (to fetch-unit stall input)
- flush_fd  output  1  kill the instruction fetched this cycle (F/D bubble)
- bd_f  output  1  the instruction in F is a delay slot (registered)

Behaviour:
- State register: pend_v (1b), pend_pc (32b), bd_q (1b). Reset clears all three to 0.
- During reset: npc=RESET_PC, pc_stall=0, flush_fd=0, bd_f=0.
- Source priority, evaluated combinationally each cycle:
  1. exc_req: npc=HANDLER_PC, pc_stall=0, flush_fd=1. Ignores stall_req. Clears pend_v and bd_q next edge.
  2. eret_req: npc=epc, pc_stall=0, flush_fd=1. Clears pend_v and bd_q. ERET has no delay slot.
  3. stall_req: pc_stall=1, npc=pc (don't-care but defined).
     - If redir_d=1 and pend_v=0: latch pend_pc=redir_target_d and set pend_v at the edge.
     - If pend_v is already 1, it is kept and the newer redir_d is ignored (same branch re-asserting).
  4. pend_v: npc=pend_pc, pc_stall=0, clear pend_v at the edge.
  5. redir_d: npc=redir_target_d, pc_stall=0.
  6. Otherwise: npc=pc+4 (32-bit wrap; no range check).
- Simultaneous cases:
  - exc_req with eret_req: exc_req wins.
  - exc_req with pend_v=1: the pending redirect is discarded.
  - redir_d with pend_v=1 and no stall: pend_pc wins, redir_d is ignored.
- bd_q is updated only on edges where pc_stall=0 and neither exc_req nor eret_req is asserted: bd_q<=cti_d. bd_f=bd_q.
- Latency:
  - Redirect and exception are visible on npc in the same cycle.
  - pc shows the new value one edge later.
  - A latched redirect is applied in the first cycle stall_req=0.

Optional Feature:
- PCSEQ_PERF_EN
  - Defined: add outputs perf_redir[31:0], perf_stall[31:0] and perf_exc[31:0].
    - perf_redir increments on each cycle npc takes a redirect (pend or redir_d).
    - perf_stall increments on each cycle pc_stall=1.
    - perf_exc increments on each exc_req cycle.
    - All three counters reset to 0, saturate at 32'hFFFFFFFF, and do not count during reset.
  - Undefined: ports and counters absent; otherwise identical behaviour.

Decomposition:
- Shared package holds:
  - constants RESET_PC_DEF=32'h3000 and HANDLER_PC_DEF=32'h4180;
  - npc-source encoding (SRC_SEQ, SRC_REDIR, SRC_PEND, SRC_EXC, SRC_ERET, SRC_HOLD) as a 3-bit typedef, exported for debug.
- One sub-module: pcseq_perf_cnt, a saturating 32-bit counter with an enable input.
  - Instantiated three times under PCSEQ_PERF_EN.

Test Plan:
- Reset release: hold reset 2 cycles with pc=32'h3000 → npc=32'h3000, bd_f=0. First free cycle gives npc=32'h3004, pc_stall=0.
- Redirect under stall: pc=32'h3010, stall_req=1, redir_d=1, target=32'h3100 for 1 cycle → pc_stall=1. Next cycle with stall_req=0 and redir_d=0 → npc=32'h3100, pend cleared.
- Exception beats stall and pending: pend_v=1 (pend_pc=32'h3200), stall_req=1, exc_req=1 → npc=32'h4180, pc_stall=0, flush_fd=1. Following cycle: npc=pc+4, not 32'h3200.
- ERET: eret_req=1, epc=32'h3024 → npc=32'h3024, flush_fd=1. Next cycle bd_f=0.
- Delay-slot flag: cti_d=1, no stall → bd_f=1 next cycle. With stall_req=1, bd_f holds its value across 3 stall cycles.
- Perf (PCSEQ_PERF_EN): 4 stall cycles, 2 redirects, 1 exception → perf_stall=4, perf_redir=2, perf_exc=1.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the next-PC sequencer: default vectors, the
// next-PC source encoding (visible on the internal src signal for debug)
// and a small classification helper.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] PC_STEP        = 32'd4;

    // Where npc comes from this cycle, highest priority first: EXC, ERET,
    // HOLD (stall), PEND (latched redirect), REDIR (live redirect), SEQ.
    typedef enum logic [2:0] {
        SRC_SEQ   = 3'd0,
        SRC_REDIR = 3'd1,
        SRC_PEND  = 3'd2,
        SRC_EXC   = 3'd3,
        SRC_ERET  = 3'd4,
        SRC_HOLD  = 3'd5
    } npc_src_e;

    // True when npc takes a branch/jump target, live or latched.
    function automatic logic is_redirect(npc_src_e src);
        return (src == SRC_REDIR) || (src == SRC_PEND);
    endfunction

endpackage

// File: rtl/pcseq_perf_cnt.sv
// Saturating 32-bit event counter: counts enabled cycles and sticks at
// all-ones instead of wrapping. Synchronous active-high reset.
module pcseq_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Advance while enabled, freeze once saturated.
    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch unit of the 5-stage MIPS pipeline.
// Picks npc from exception entry, ERET return, stall hold, a redirect
// latched during a stall, a live D-stage redirect, or pc+4. Also drives
// the PC stall, the F/D flush and the registered delay-slot flag for CP0.
// Optional build macro PCSEQ_PERF_EN adds saturating perf counters
// perf_redir, perf_stall and perf_exc.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall_req,
    input  logic        cti_d,
    input  logic        redir_d,
    input  logic [31:0] redir_target_d,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] npc,
    output logic        pc_stall,
    output logic        flush_fd,
    output logic        bd_f
`ifdef PCSEQ_PERF_EN
    ,
    output logic [31:0] perf_redir,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_exc
`endif
);

    npc_src_e    src;
    logic        pend_v_q,  pend_v_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        bd_q,      bd_d;

    // Select the npc source by fixed priority.
    always_comb begin
        if (exc_req) begin
            src = SRC_EXC;
        end else if (eret_req) begin
            src = SRC_ERET;
        end else if (stall_req) begin
            src = SRC_HOLD;
        end else if (pend_v_q) begin
            src = SRC_PEND;
        end else if (redir_d) begin
            src = SRC_REDIR;
        end else begin
            src = SRC_SEQ;
        end
    end

    // Next state: keep a redirect seen during a stall, drop it once used
    // or on exception/ERET; the BD flag follows cti_d only on free cycles.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        pend_v_d  = pend_v_q;
        pend_pc_d = pend_pc_q;
        bd_d      = bd_q;
        unique case (src)
            SRC_EXC, SRC_ERET: begin
                pend_v_d = 1'b0;
                bd_d     = 1'b0;
            end
            SRC_HOLD: begin
                // The first redirect of a stall wins; re-assertions of the
                // same branch while it is held are ignored.
                if (redir_d && !pend_v_q) begin
                    pend_v_d  = 1'b1;
                    pend_pc_d = redir_target_d;
                end
            end
            default: begin
                pend_v_d = 1'b0;
                bd_d     = cti_d;
            end
        endcase
    end

    // Output decode from the selected source; reset forces the boot vector.
    always_comb begin
        npc      = pc + PC_STEP;
        pc_stall = 1'b0;
        flush_fd = 1'b0;
        if (reset) begin
            npc = RESET_PC;
        end else begin
            unique case (src)
                SRC_EXC: begin
                    npc      = HANDLER_PC;
                    flush_fd = 1'b1;
                end
                SRC_ERET: begin
                    npc      = epc;
                    flush_fd = 1'b1;
                end
                SRC_HOLD: begin
                    npc      = pc;
                    pc_stall = 1'b1;
                end
                SRC_PEND:  npc = pend_pc_q;
                SRC_REDIR: npc = redir_target_d;
                default:   npc = pc + PC_STEP;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge (synchronous), and all
        // sequential state uses non-blocking assignments so every register
        // sees pre-edge values regardless of statement order.
        if (reset) begin
            pend_v_q  <= 1'b0;
            pend_pc_q <= '0;
            bd_q      <= 1'b0;
        end else begin
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
            bd_q      <= bd_d;
        end
    end

    // bd_q may hold anything before the first reset edge; mask it.
    assign bd_f = bd_q & ~reset;

`ifdef PCSEQ_PERF_EN
    pcseq_perf_cnt u_cnt_redir (
        .clk     (clk),
        .reset   (reset),
        .en_i    (is_redirect(src)),
        .count_o (perf_redir)
    );

    pcseq_perf_cnt u_cnt_stall (
        .clk     (clk),
        .reset   (reset),
        .en_i    (pc_stall),
        .count_o (perf_stall)
    );

    pcseq_perf_cnt u_cnt_exc (
        .clk     (clk),
        .reset   (reset),
        .en_i    (exc_req),
        .count_o (perf_exc)
    );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by a
// randomized run against a behavioural model of the next-PC rules.
// Build with PCSEQ_PERF_EN defined to also exercise the perf counters.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] HND_PC = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        stall_req, cti_d, redir_d, exc_req, eret_req;
    logic [31:0] redir_target_d, epc;
    logic [31:0] npc;
    logic        pc_stall, flush_fd, bd_f;
`ifdef PCSEQ_PERF_EN
    logic [31:0] perf_redir, perf_stall, perf_exc;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .stall_req      (stall_req),
        .cti_d          (cti_d),
        .redir_d        (redir_d),
        .redir_target_d (redir_target_d),
        .exc_req        (exc_req),
        .eret_req       (eret_req),
        .epc            (epc),
        .npc            (npc),
        .pc_stall       (pc_stall),
        .flush_fd       (flush_fd),
        .bd_f           (bd_f)
`ifdef PCSEQ_PERF_EN
        ,
        .perf_redir     (perf_redir),
        .perf_stall     (perf_stall),
        .perf_exc       (perf_exc)
`endif
    );

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [31:0] npc;
        logic        stall;
        logic        flush;
        logic        redir;
    } exp_t;

    bit          m_pend;
    logic [31:0] m_pend_pc;
    bit          m_bd;
    int unsigned m_redir, m_stall, m_exc;

    function automatic exp_t model_out();
        exp_t e;
        e = '{npc: pc + 32'd4, stall: 1'b0, flush: 1'b0, redir: 1'b0};
        if (reset)              e.npc = RST_PC;
        else if (exc_req)     begin e.npc = HND_PC; e.flush = 1'b1; end
        else if (eret_req)    begin e.npc = epc;    e.flush = 1'b1; end
        else if (stall_req)   begin e.npc = pc;     e.stall = 1'b1; end
        else if (m_pend)      begin e.npc = m_pend_pc;      e.redir = 1'b1; end
        else if (redir_d)     begin e.npc = redir_target_d; e.redir = 1'b1; end
        return e;
    endfunction

    task automatic model_edge(input exp_t e);
        if (reset) begin
            m_pend = 0; m_pend_pc = '0; m_bd = 0;
            m_redir = 0; m_stall = 0; m_exc = 0;
        end else begin
            if (e.stall) m_stall++;
            if (e.redir) m_redir++;
            if (exc_req) m_exc++;
            if (exc_req || eret_req) begin
                m_pend = 0; m_bd = 0;
            end else if (stall_req) begin
                if (redir_d && !m_pend) begin
                    m_pend = 1; m_pend_pc = redir_target_d;
                end
            end else begin
                m_pend = 0; m_bd = cti_d;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        stall_req = 0; cti_d = 0; redir_d = 0; exc_req = 0; eret_req = 0;
        redir_target_d = '0; epc = '0;
    endtask

    task automatic to_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1; pc = RST_PC; cti_d = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (npc !== RST_PC) begin n_bad++; $display("FAIL reset_npc: got %h want %h", npc, RST_PC); end
            n_cmp++; if (bd_f !== 1'b0) begin n_bad++; $display("FAIL reset_bd: got %b want 0", bd_f); end
            n_cmp++; if ({pc_stall, flush_fd} !== 2'b00) begin n_bad++; $display("FAIL reset_ctl: got %b want 00", {pc_stall, flush_fd}); end
            to_edge();
        end
        reset = 0; cti_d = 0;
        @(negedge clk);
        n_cmp++; if (npc !== 32'h3004) begin n_bad++; $display("FAIL first_npc: got %h want 00003004", npc); end
        n_cmp++; if (pc_stall !== 1'b0) begin n_bad++; $display("FAIL first_stall: got %b want 0", pc_stall); end
        to_edge();
    endtask

    task automatic test_redirect_stall();
        idle_inputs();
        pc = 32'h3010; stall_req = 1; redir_d = 1; redir_target_d = 32'h3100;
        @(negedge clk);
        n_cmp++; if (pc_stall !== 1'b1) begin n_bad++; $display("FAIL rs_stall: got %b want 1", pc_stall); end
        n_cmp++; if (npc !== 32'h3010) begin n_bad++; $display("FAIL rs_hold_npc: got %h want 00003010", npc); end
        to_edge();
        redir_target_d = 32'h3200;          // newer redirect while held: ignored
        @(negedge clk);
        n_cmp++; if (pc_stall !== 1'b1) begin n_bad++; $display("FAIL rs_stall2: got %b want 1", pc_stall); end
        to_edge();
        stall_req = 0; redir_target_d = 32'h3300;  // live redirect loses to pending
        @(negedge clk);
        n_cmp++; if (npc !== 32'h3100) begin n_bad++; $display("FAIL rs_pend_npc: got %h want 00003100", npc); end
        n_cmp++; if (pc_stall !== 1'b0) begin n_bad++; $display("FAIL rs_release: got %b want 0", pc_stall); end
        to_edge();
        idle_inputs(); pc = 32'h3100;
        @(negedge clk);
        n_cmp++; if (npc !== 32'h3104) begin n_bad++; $display("FAIL rs_pend_clr: got %h want 00003104", npc); end
        to_edge();
        redir_d = 1; redir_target_d = 32'h3400; pc = 32'h3104;
        @(negedge clk);
        n_cmp++; if (npc !== 32'h3400) begin n_bad++; $display("FAIL live_redir: got %h want 00003400", npc); end
        to_edge();
    endtask

    task automatic test_exception();
        idle_inputs();
        pc = 32'h3400; stall_req = 1; redir_d = 1; redir_target_d = 32'h3200;
        to_edge();
        redir_d = 0; exc_req = 1; eret_req = 1; epc = 32'h3024;
        @(negedge clk);
        n_cmp++; if (npc !== HND_PC) begin n_bad++; $display("FAIL exc_npc: got %h want %h", npc, HND_PC); end
        n_cmp++; if ({pc_stall, flush_fd} !== 2'b01) begin n_bad++; $display("FAIL exc_ctl: got %b want 01", {pc_stall, flush_fd}); end
        to_edge();
        idle_inputs(); pc = HND_PC;
        @(negedge clk);
        n_cmp++; if (npc !== 32'h4184) begin n_bad++; $display("FAIL exc_drop_pend: got %h want 00004184", npc); end
        n_cmp++; if (flush_fd !== 1'b0) begin n_bad++; $display("FAIL exc_flush_end: got %b want 0", flush_fd); end
        to_edge();
    endtask

    task automatic test_eret();
        idle_inputs();
        pc = 32'h4184; cti_d = 1;
        to_edge();
        eret_req = 1; epc = 32'h3024;
        @(negedge clk);
        n_cmp++; if (bd_f !== 1'b1) begin n_bad++; $display("FAIL eret_bd_pre: got %b want 1", bd_f); end
        n_cmp++; if (npc !== 32'h3024) begin n_bad++; $display("FAIL eret_npc: got %h want 00003024", npc); end
        n_cmp++; if (flush_fd !== 1'b1) begin n_bad++; $display("FAIL eret_flush: got %b want 1", flush_fd); end
        to_edge();
        idle_inputs(); pc = 32'h3024;
        @(negedge clk);
        n_cmp++; if (bd_f !== 1'b0) begin n_bad++; $display("FAIL eret_bd_clr: got %b want 0", bd_f); end
        n_cmp++; if (npc !== 32'h3028) begin n_bad++; $display("FAIL eret_next: got %h want 00003028", npc); end
        to_edge();
    endtask

    task automatic test_delay_slot();
        idle_inputs();
        pc = 32'h3028; cti_d = 1;
        to_edge();
        cti_d = 0; stall_req = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (bd_f !== 1'b1) begin n_bad++; $display("FAIL bd_hold%0d: got %b want 1", i, bd_f); end
            to_edge();
        end
        stall_req = 0;
        @(negedge clk);
        n_cmp++; if (bd_f !== 1'b1) begin n_bad++; $display("FAIL bd_release: got %b want 1", bd_f); end
        to_edge();
        @(negedge clk);
        n_cmp++; if (bd_f !== 1'b0) begin n_bad++; $display("FAIL bd_clear: got %b want 0", bd_f); end
        to_edge();
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        exp_t e;
        idle_inputs();
        reset = 1; pc = RST_PC;
        e = model_out();
        to_edge();
        model_edge(e);
        reset = 0;
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 99) < 2);
            stall_req      = ($urandom_range(0, 99) < 30);
            redir_d        = ($urandom_range(0, 99) < 25);
            exc_req        = ($urandom_range(0, 99) < 6);
            eret_req       = ($urandom_range(0, 99) < 6);
            cti_d          = ($urandom_range(0, 99) < 30);
            redir_target_d = $urandom & 32'hFFFF_FFFC;
            epc            = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 99) < 2) pc = 32'hFFFF_FFFC;   // wrap case
            e = model_out();
            @(negedge clk);
            n_cmp++; if (npc !== e.npc) begin n_bad++; $display("FAIL rnd_npc[%0d]: got %h want %h", i, npc, e.npc); end
            n_cmp++; if (pc_stall !== e.stall) begin n_bad++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, pc_stall, e.stall); end
            n_cmp++; if (flush_fd !== e.flush) begin n_bad++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, flush_fd, e.flush); end
            n_cmp++; if (bd_f !== (m_bd && !reset)) begin n_bad++; $display("FAIL rnd_bd[%0d]: got %b want %b", i, bd_f, m_bd && !reset); end
            to_edge();
            model_edge(e);
            pc = reset ? RST_PC : (e.stall ? pc : e.npc);
        end
        idle_inputs(); reset = 0;
`ifdef PCSEQ_PERF_EN
        @(negedge clk);
        n_cmp++; if (perf_redir !== m_redir) begin n_bad++; $display("FAIL rnd_perf_redir: got %0d want %0d", perf_redir, m_redir); end
        n_cmp++; if (perf_stall !== m_stall) begin n_bad++; $display("FAIL rnd_perf_stall: got %0d want %0d", perf_stall, m_stall); end
        n_cmp++; if (perf_exc !== m_exc) begin n_bad++; $display("FAIL rnd_perf_exc: got %0d want %0d", perf_exc, m_exc); end
`endif
        to_edge();
    endtask

`ifdef PCSEQ_PERF_EN
    task automatic test_perf();
        idle_inputs();
        reset = 1; pc = RST_PC; stall_req = 1; exc_req = 1;   // must not count
        to_edge();
        reset = 0; exc_req = 0;
        @(negedge clk);
        n_cmp++; if ({perf_redir, perf_stall, perf_exc} !== '0) begin n_bad++; $display("FAIL perf_reset: got %0d/%0d/%0d want 0/0/0", perf_redir, perf_stall, perf_exc); end
        for (int i = 0; i < 4; i++) to_edge();                 // 4 stall cycles incl. above
        stall_req = 0; redir_d = 1; redir_target_d = 32'h3500;
        to_edge();
        redir_target_d = 32'h3600;
        to_edge();
        redir_d = 0; exc_req = 1;
        to_edge();
        idle_inputs();
        @(negedge clk);
        n_cmp++; if (perf_stall !== 32'd4) begin n_bad++; $display("FAIL perf_stall: got %0d want 4", perf_stall); end
        n_cmp++; if (perf_redir !== 32'd2) begin n_bad++; $display("FAIL perf_redir: got %0d want 2", perf_redir); end
        n_cmp++; if (perf_exc !== 32'd1) begin n_bad++; $display("FAIL perf_exc: got %0d want 1", perf_exc); end
        to_edge();
    endtask
`endif

    initial begin
        test_reset();
        test_redirect_stall();
        test_exception();
        test_eret();
        test_delay_slot();
        test_random();
`ifdef PCSEQ_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
